// File: rtl/seq_counter_pkg.sv
// Shared constants for the parametrised sequence counter: mode encodings
// and a small Gray-code helper used by the next-state logic.
package seq_counter_pkg;

  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_GRAY    = 2'b10;
  localparam logic [1:0] MODE_JOHNSON = 2'b11;

  // Reflected binary-to-Gray for a 32-bit container; callers truncate.
  function automatic logic [31:0] bin_to_gray32(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational reflected-Gray to binary converter, parametrised by WIDTH.
module gray_to_bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/param_seq_counter.sv
// Parametrised sequence counter: binary up/down (period MODULUS), Gray up
// and Johnson sequences from a single state register, with parallel load,
// a combinational terminal-count flag and a registered wrap pulse.
module param_seq_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  // Binary range checks are done one bit wider so MODULUS == 2**WIDTH fits.
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   LAST_W   = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LAST_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [WIDTH-1:0] q_bin;
  logic [WIDTH-1:0] q_bin_inc;
  logic [WIDTH-1:0] next_q;
  logic [31:0]      gray_next32;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray (Q),
    .bin  (q_bin)
  );

  assign q_bin_inc   = q_bin + ONE;
  assign gray_next32 = bin_to_gray32(32'(q_bin_inc));

  // Mode-selected next state, always computed from the current Q so a mode
  // change simply redirects the very next step.
  always_comb begin
    next_q = Q;
    case (mode)
      MODE_UP: begin
        if ({1'b0, Q} >= LAST_W) next_q = '0;
        else                     next_q = Q + ONE;
      end
      MODE_DOWN: begin
        if (Q == '0 || {1'b0, Q} >= MOD_W) next_q = LAST_Q;
        else                               next_q = Q - ONE;
      end
      MODE_GRAY: begin
        next_q = gray_next32[WIDTH-1:0];
      end
      default: begin
        // Illegal Johnson states are shifted as-is; no self-correction.
        next_q = {Q[WIDTH-2:0], ~Q[WIDTH-1]};
      end
    endcase
  end

  // Terminal count: Q sits on the last state of the selected sequence.
  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_UP:   tc = (Q == LAST_Q);
      MODE_DOWN: tc = (Q == '0);
      default:   tc = (Q == MSB_ONLY);
    endcase
  end

  // State register; load beats count, and wrap marks a step taken from tc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      Q    <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      Q    <= next_q;
      wrap <= tc;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_seq_counter.sv
// Directed bench for param_seq_counter (WIDTH=3, MODULUS=6). Each task drives
// one scenario and compares Q, tc and wrap against hand-computed tables.
module tb_param_seq_counter;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;

  int n_checks = 0;
  int n_fail   = 0;

  param_seq_counter #(.WIDTH(W), .MODULUS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .Q        (q),
    .tc       (tc),
    .wrap     (wrap)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; load = 1'b0; load_val = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mode = 2'b00;
    #1;
    n_checks++;
    if (q !== 3'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_up: q=%0d wrap=%b tc=%b, required q=0 wrap=0 tc=0", q, wrap, tc);
    end
    mode = 2'b01;
    #1;
    n_checks++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_down_tc: tc=%b, required 1", tc);
    end
  endtask

  task automatic test_up();
    logic [W-1:0] exp_q [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic         exp_tc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         exp_w [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (q !== exp_q[i] || tc !== exp_tc[i] || wrap !== exp_w[i]) begin
        n_fail++;
        $display("FAIL up step %0d: q=%0d tc=%b wrap=%b, required q=%0d tc=%b wrap=%b",
                 i, q, tc, wrap, exp_q[i], exp_tc[i], exp_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down();
    logic [W-1:0] exp_q [8] = '{3'd7, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    logic         exp_tc[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    mode = 2'b01;
    load = 1'b1; load_val = 3'd7;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0; en = 1'b1;
      n_checks++;
      if (q !== exp_q[i] || tc !== exp_tc[i] || wrap !== exp_w[i]) begin
        n_fail++;
        $display("FAIL down step %0d: q=%0d tc=%b wrap=%b, required q=%0d tc=%b wrap=%b",
                 i, q, tc, wrap, exp_q[i], exp_tc[i], exp_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_gray();
    logic [W-1:0] exp_q [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic         exp_tc[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    mode = 2'b10; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (q !== exp_q[i] || tc !== exp_tc[i] || wrap !== exp_w[i]) begin
        n_fail++;
        $display("FAIL gray step %0d: q=%b tc=%b wrap=%b, required q=%b tc=%b wrap=%b",
                 i, q, tc, wrap, exp_q[i], exp_tc[i], exp_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_johnson();
    logic [W-1:0] exp_q [6] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    logic         exp_tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         exp_w [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    mode = 2'b11; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (q !== exp_q[i] || tc !== exp_tc[i] || wrap !== exp_w[i]) begin
        n_fail++;
        $display("FAIL johnson step %0d: q=%b tc=%b wrap=%b, required q=%b tc=%b wrap=%b",
                 i, q, tc, wrap, exp_q[i], exp_tc[i], exp_w[i]);
      end
    end
    // Illegal state 010 shifts to 101 with no correction.
    en = 1'b0; load = 1'b1; load_val = 3'b010;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    n_checks++;
    if (q !== 3'b101) begin
      n_fail++;
      $display("FAIL johnson_illegal: q=%b, required 101", q);
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    mode = 2'b00; en = 1'b1;
    tick();
    load = 1'b1; load_val = 3'd3;
    tick();
    n_checks++;
    if (q !== 3'd3 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL load_with_en: q=%0d wrap=%b, required q=3 wrap=0", q, wrap);
    end
    en = 1'b0; load_val = 3'd6;
    tick();
    n_checks++;
    if (q !== 3'd6) begin
      n_fail++;
      $display("FAIL load_no_en: q=%0d, required 6", q);
    end
    load = 1'b0;
    tick();
    tick();
    n_checks++;
    if (q !== 3'd6 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: q=%0d wrap=%b, required q=6 wrap=0", q, wrap);
    end
    // Out-of-range value recovers to 0 in up mode; tc was low so no wrap.
    en = 1'b1;
    tick();
    n_checks++;
    if (q !== 3'd0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL up_recover: q=%0d wrap=%b, required q=0 wrap=0", q, wrap);
    end
    // Out-of-range value in down mode goes to MODULUS-1.
    en = 1'b0; load = 1'b1; load_val = 3'd6;
    tick();
    load = 1'b0; en = 1'b1; mode = 2'b01;
    tick();
    n_checks++;
    if (q !== 3'd5 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL down_recover: q=%0d wrap=%b, required q=5 wrap=0", q, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 2'b00; en = 1'b1;
    tick();
    tick();
    n_checks++;
    if (q !== 3'd2) begin
      n_fail++;
      $display("FAIL switch_pre: q=%0d, required 2", q);
    end
    mode = 2'b01;
    tick();
    n_checks++;
    if (q !== 3'd1) begin
      n_fail++;
      $display("FAIL switch_down: q=%0d, required 1", q);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (q !== 3'd4) begin
      n_fail++;
      $display("FAIL async_pre: q=%0d, required 4", q);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (q !== 3'd0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: q=%0d wrap=%b, required q=0 wrap=0", q, wrap);
    end
    // Load requested while reset is held is cancelled.
    load = 1'b1; load_val = 3'd5;
    tick();
    n_checks++;
    if (q !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_over_load: q=%0d, required 0", q);
    end
    load = 1'b0; rst = 1'b0;
    tick();
    n_checks++;
    if (q !== 3'd1) begin
      n_fail++;
      $display("FAIL first_after_rst: q=%0d, required 1", q);
    end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
    test_reset();
    test_up();
    test_down();
    test_gray();
    test_johnson();
    test_load();
    test_mode_switch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
